// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - scanned four-digit common-anode seven-segment driver with blanking gap and per-frame latch
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (blank leading zero digits 3..1)
module seg7_scan_driver #(
   parameter int BLANK_CYCLES = 16,
   parameter int SYNC_STAGES  = 2
) (
   input  logic        CLK_IN,
   input  logic        RST_N,
   input  logic        SCAN_CLK,
   input  logic [15:0] VALUE,
   input  logic [3:0]  DP,
   input  logic [3:0]  DIGIT_EN,
   output logic [3:0]  AN,
   output logic [6:0]  SEG,
   output logic        DP_OUT,
   output logic        FRAME_DONE
);

   localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int CW = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BLANK = 2'd1;
   localparam logic [1:0] S_DRIVE = 2'd2;

   logic [NS-1:0] sync_q;
   logic          edge_q;
   logic          tick_q;

   logic [1:0]    state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   val_q, val_d;
   logic [3:0]    dpm_q, dpm_d;
   logic [3:0]    en_q, en_d;
   logic          fd_q, fd_d;

   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dpo_q, dpo_d;

   logic [3:0]    nib_d;
   logic          lz_d;
   logic          show_d;

   // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble
   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: hex_seg = 7'b1000000;
         4'h1: hex_seg = 7'b1111001;
         4'h2: hex_seg = 7'b0100100;
         4'h3: hex_seg = 7'b0110000;
         4'h4: hex_seg = 7'b0011001;
         4'h5: hex_seg = 7'b0010010;
         4'h6: hex_seg = 7'b0000010;
         4'h7: hex_seg = 7'b1111000;
         4'h8: hex_seg = 7'b0000000;
         4'h9: hex_seg = 7'b0010000;
         4'hA: hex_seg = 7'b0001000;
         4'hB: hex_seg = 7'b0000011;
         4'hC: hex_seg = 7'b1000110;
         4'hD: hex_seg = 7'b0100001;
         4'hE: hex_seg = 7'b0000110;
         default: hex_seg = 7'b0001110;
      endcase
   endfunction

   // Synchronise SCAN_CLK and turn its rising edge into a registered one-cycle tick
   always_ff @(posedge CLK_IN) begin
      if (!RST_N) begin
         sync_q <= '0;
         edge_q <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[NS-2:0], SCAN_CLK};
         edge_q <= sync_q[NS-1];
         tick_q <= sync_q[NS-1] & ~edge_q;
      end
   end

   // Scan sequencing: a tick always advances the digit and restarts the blanking gap
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      val_d   = val_q;
      dpm_d   = dpm_q;
      en_d    = en_q;
      fd_d    = 1'b0;
      if (tick_q) begin
         idx_d   = idx_q + 2'd1;
         state_d = S_BLANK;
         cnt_d   = CW'(BLANK_CYCLES);
         // Wrapping to digit 0 starts a new frame, so the inputs are captured here only
         if (idx_q == 2'd3) begin
            val_d = VALUE;
            dpm_d = DP;
            en_d  = DIGIT_EN;
            fd_d  = 1'b1;
         end
      end else if (state_q == S_BLANK) begin
         // Counter holds the remaining gap length; a zero gap still costs one blank cycle
         if (cnt_q <= CW'(1)) begin
            state_d = S_DRIVE;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end
   end

   // Output decode from next state so that every output pin comes straight from a flop
   always_comb begin
      nib_d = 4'(val_d >> {idx_d, 2'b00});
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      case (idx_d)
         2'd1:    lz_d = (val_d[15:4] == 12'h000);
         2'd2:    lz_d = (val_d[15:8] == 8'h00);
         2'd3:    lz_d = (val_d[15:12] == 4'h0);
         default: lz_d = 1'b0;
      endcase
`else
      lz_d = 1'b0;
`endif
      show_d = (state_d == S_DRIVE) && en_d[idx_d] && !lz_d;
      an_d   = show_d ? ~(4'b0001 << idx_d) : 4'hF;
      seg_d  = show_d ? hex_seg(nib_d) : 7'h7F;
      dpo_d  = show_d ? ~dpm_d[idx_d] : 1'b1;
   end

   // State, shadow and output registers
   always_ff @(posedge CLK_IN) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd3;
         cnt_q   <= '0;
         val_q   <= '0;
         dpm_q   <= '0;
         en_q    <= '0;
         fd_q    <= 1'b0;
         an_q    <= 4'hF;
         seg_q   <= 7'h7F;
         dpo_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         val_q   <= val_d;
         dpm_q   <= dpm_d;
         en_q    <= en_d;
         fd_q    <= fd_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dpo_q   <= dpo_d;
      end
   end

   assign AN         = an_q;
   assign SEG        = seg_q;
   assign DP_OUT     = dpo_q;
   assign FRAME_DONE = fd_q;

endmodule
